// File: rtl/otter_hazard_unit.sv
// rtl/otter_hazard_unit.sv - pipeline hazard detection, stall/flush control and operand forwarding select
// Optional feature macro: OTTER_HAZ_FWD_EN
//   defined   : results are forwarded from any tracked stage; stall only on load-use at stage 1
//   undefined : no forwarding (FWD_A/FWD_B are 0); stall on any hit in stages 1..DEPTH
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   DEC_VALID                 decode register holds a real instruction
//   DEC_RS1/DEC_RS2           decode source addresses, qualified by DEC_USE1/DEC_USE2
//   DEC_RD/DEC_WR/DEC_LOAD    decode destination, write enable, load flag
//   BR_TAKEN                  execute stage redirects the PC this cycle
//   STALL                     hold PC and decode register
//   FLUSH                     clear decode register at next edge (equals BR_TAKEN)
//   FWD_A/FWD_B               operand source: 0 = register file, k = stage k result
//   STALL_CNT                 saturating count of stall cycles
module otter_hazard_unit #(
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DEC_VALID,
  input  logic [4:0]       DEC_RS1,
  input  logic [4:0]       DEC_RS2,
  input  logic             DEC_USE1,
  input  logic             DEC_USE2,
  input  logic [4:0]       DEC_RD,
  input  logic             DEC_WR,
  input  logic             DEC_LOAD,
  input  logic             BR_TAKEN,
  output logic             STALL,
  output logic             FLUSH,
  output logic [2:0]       FWD_A,
  output logic [2:0]       FWD_B,
  output logic [CNT_W-1:0] STALL_CNT
);

  // Entry k describes the instruction currently in stage k (1 = execute).
  logic [DEPTH:1] ent_valid;
  logic [4:0]     ent_rd [1:DEPTH];
  logic [DEPTH:1] ent_load;

  logic [DEPTH:1] hit_a;
  logic [DEPTH:1] hit_b;
  logic           stall_raw;
  logic [CNT_W-1:0] stall_cnt;

  always_comb begin
    hit_a = '0;
    hit_b = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      hit_a[k] = ent_valid[k] && (ent_rd[k] == DEC_RS1) && DEC_USE1 && DEC_VALID && (DEC_RS1 != 5'd0);
      hit_b[k] = ent_valid[k] && (ent_rd[k] == DEC_RS2) && DEC_USE2 && DEC_VALID && (DEC_RS2 != 5'd0);
    end
  end

`ifdef OTTER_HAZ_FWD_EN
  logic [2:0] fwd_a_sel;
  logic [2:0] fwd_b_sel;

  // Scan oldest to youngest so the youngest (lowest k) hit is the one left standing.
  always_comb begin
    fwd_a_sel = 3'd0;
    fwd_b_sel = 3'd0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (hit_a[k]) fwd_a_sel = 3'(k);
      if (hit_b[k]) fwd_b_sel = 3'(k);
    end
  end

  // A load in execute has no result yet; everything older can be forwarded.
  assign stall_raw = (hit_a[1] || hit_b[1]) && ent_load[1];
  assign FWD_A     = STALL ? 3'd0 : fwd_a_sel;
  assign FWD_B     = STALL ? 3'd0 : fwd_b_sel;
`else
  logic unused_load;
  assign unused_load = ^{ent_load, DEC_LOAD};

  // Without forwarding every in-flight writer blocks, writeback included,
  // because the register file only commits at the end of the cycle.
  assign stall_raw = |(hit_a | hit_b);
  assign FWD_A     = 3'd0;
  assign FWD_B     = 3'd0;
`endif

  // Flush wins: the decode instruction is being discarded, so nothing to wait for.
  assign FLUSH     = BR_TAKEN;
  assign STALL     = stall_raw && !BR_TAKEN;
  assign STALL_CNT = stall_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ent_valid <= '0;
      ent_load  <= '0;
      for (int k = 1; k <= DEPTH; k++) ent_rd[k] <= 5'd0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        ent_valid[k] <= ent_valid[k-1];
        ent_rd[k]    <= ent_rd[k-1];
        ent_load[k]  <= ent_load[k-1];
      end
      if (!STALL && !FLUSH) begin
        ent_valid[1] <= DEC_VALID && DEC_WR && (DEC_RD != 5'd0);
        ent_rd[1]    <= DEC_RD;
        ent_load[1]  <= DEC_LOAD;
      end else begin
        ent_valid[1] <= 1'b0;
        ent_rd[1]    <= 5'd0;
        ent_load[1]  <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt <= '0;
    end else if (STALL && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_otter_hazard_unit.sv
// tb/tb_otter_hazard_unit.sv - scoreboard bench for otter_hazard_unit (both OTTER_HAZ_FWD_EN builds)
module tb_otter_hazard_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        DEC_VALID = 1'b0;
  logic [4:0]  DEC_RS1 = 5'd0;
  logic [4:0]  DEC_RS2 = 5'd0;
  logic        DEC_USE1 = 1'b0;
  logic        DEC_USE2 = 1'b0;
  logic [4:0]  DEC_RD = 5'd0;
  logic        DEC_WR = 1'b0;
  logic        DEC_LOAD = 1'b0;
  logic        BR_TAKEN = 1'b0;
  logic        STALL;
  logic        FLUSH;
  logic [2:0]  FWD_A;
  logic [2:0]  FWD_B;
  logic [15:0] STALL_CNT;

  logic        stall2;
  logic        flush2;
  logic [2:0]  fwd_a2;
  logic [2:0]  fwd_b2;
  logic [1:0]  cnt2;

  otter_hazard_unit #(.DEPTH(3), .CNT_W(16)) u_dut (
    .CLK(CLK), .RST(RST), .DEC_VALID(DEC_VALID), .DEC_RS1(DEC_RS1), .DEC_RS2(DEC_RS2),
    .DEC_USE1(DEC_USE1), .DEC_USE2(DEC_USE2), .DEC_RD(DEC_RD), .DEC_WR(DEC_WR),
    .DEC_LOAD(DEC_LOAD), .BR_TAKEN(BR_TAKEN), .STALL(STALL), .FLUSH(FLUSH),
    .FWD_A(FWD_A), .FWD_B(FWD_B), .STALL_CNT(STALL_CNT)
  );

  // Narrow-counter copy fed with the same stimulus to observe saturation.
  otter_hazard_unit #(.DEPTH(3), .CNT_W(2)) u_sat (
    .CLK(CLK), .RST(RST), .DEC_VALID(DEC_VALID), .DEC_RS1(DEC_RS1), .DEC_RS2(DEC_RS2),
    .DEC_USE1(DEC_USE1), .DEC_USE2(DEC_USE2), .DEC_RD(DEC_RD), .DEC_WR(DEC_WR),
    .DEC_LOAD(DEC_LOAD), .BR_TAKEN(BR_TAKEN), .STALL(stall2), .FLUSH(flush2),
    .FWD_A(fwd_a2), .FWD_B(fwd_b2), .STALL_CNT(cnt2)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [2:0]  fa;
    logic [2:0]  fb;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   m16 = 0;
  int   m2 = 0;

  // Monitor: one expected record per driven cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({STALL, FLUSH, FWD_A, FWD_B, STALL_CNT, cnt2} !== {e.stall, e.flush, e.fa, e.fb, e.cnt, e.cnt2}) begin
          failures++;
          $display("FAIL %s: got stall=%0b flush=%0b fwd_a=%0d fwd_b=%0d cnt=%0d cnt2=%0d, want stall=%0b flush=%0b fwd_a=%0d fwd_b=%0d cnt=%0d cnt2=%0d",
                   e.nm, STALL, FLUSH, FWD_A, FWD_B, STALL_CNT, cnt2,
                   e.stall, e.flush, e.fa, e.fb, e.cnt, e.cnt2);
        end
      end
    end
  end

  task automatic drive(input bit rst, input bit v, input logic [4:0] rs1, input bit u1,
                       input logic [4:0] rs2, input bit u2, input logic [4:0] rd, input bit wr,
                       input bit ld, input bit br, input bit es, input logic [2:0] efa,
                       input logic [2:0] efb, input string nm);
    exp_t e;
    @(posedge CLK);
    #1;
    RST = rst; DEC_VALID = v; DEC_RS1 = rs1; DEC_USE1 = u1; DEC_RS2 = rs2; DEC_USE2 = u2;
    DEC_RD = rd; DEC_WR = wr; DEC_LOAD = ld; BR_TAKEN = br;
    if (rst) begin
      m16 = 0;
      m2  = 0;
    end
    e.stall = es; e.flush = br; e.fa = efa; e.fb = efb;
    e.cnt = 16'(m16); e.cnt2 = 2'(m2); e.nm = nm;
    q.push_back(e);
    if (!rst && es) begin
      if (m16 < 65535) m16++;
      if (m2 < 3) m2++;
    end
  endtask

  task automatic idle(input string nm);
    drive(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 3'd0, 3'd0, nm);
  endtask

  task automatic wr_ins(input logic [4:0] rd, input bit ld, input string nm);
    drive(0, 1, 5'd0, 0, 5'd0, 0, rd, 1, ld, 0, 0, 3'd0, 3'd0, nm);
  endtask

  initial begin
    drive(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 3'd0, 3'd0, "reset");
    idle("idle0");
    idle("idle1");
`ifdef OTTER_HAZ_FWD_EN
    wr_ins(5'd5, 0, "add_x5");
    drive(0, 1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0, 3'd1, 3'd0, "fwd_stage1");
    idle("fwd_one_cycle");
    wr_ins(5'd5, 0, "add_x5_b");
    idle("gap");
    drive(0, 1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0, 3'd2, 3'd0, "fwd_stage2");
    wr_ins(5'd7, 1, "lw_x7");
    drive(0, 1, 5'd0, 0, 5'd7, 1, 5'd0, 0, 0, 0, 1, 3'd0, 3'd0, "load_use_stall");
    drive(0, 1, 5'd0, 0, 5'd7, 1, 5'd0, 0, 0, 0, 0, 3'd0, 3'd2, "load_fwd_stage2");
    idle("load_cnt1");
    wr_ins(5'd8, 0, "add_x8_a");
    wr_ins(5'd8, 0, "add_x8_b");
    drive(0, 1, 5'd8, 1, 5'd8, 1, 5'd0, 0, 0, 0, 0, 3'd1, 3'd1, "youngest_wins");
    wr_ins(5'd10, 0, "add_x10");
    idle("gap1");
    idle("gap2");
    drive(0, 1, 5'd10, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0, 3'd3, 3'd0, "fwd_writeback");
    wr_ins(5'd0, 0, "wr_x0");
    drive(0, 1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0, 0, 3'd0, 3'd0, "x0_no_hit");
    wr_ins(5'd4, 1, "lw_x4");
    drive(0, 1, 5'd4, 1, 5'd0, 0, 5'd6, 1, 0, 1, 0, 3'd1, 3'd0, "flush_beats_stall");
    drive(0, 1, 5'd6, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0, 3'd0, 3'd0, "flushed_bubble");
    for (int i = 0; i < 5; i++) begin
      wr_ins(5'd7, 1, "sat_lw");
      drive(0, 1, 5'd7, 1, 5'd0, 0, 5'd0, 0, 0, 0, 1, 3'd0, 3'd0, "sat_stall");
      drive(0, 1, 5'd7, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0, 3'd2, 3'd0, "sat_fwd");
    end
    idle("sat_hold");
    wr_ins(5'd5, 1, "lw_x5");
    drive(0, 1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0, 1, 3'd0, 3'd0, "pre_reset_stall");
    drive(1, 1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0, 3'd0, 3'd0, "reset_mid_stall");
`else
    wr_ins(5'd3, 0, "addi_x3");
    drive(0, 1, 5'd3, 1, 5'd0, 0, 5'd0, 0, 0, 0, 1, 3'd0, 3'd0, "stall_s1");
    drive(0, 1, 5'd3, 1, 5'd0, 0, 5'd0, 0, 0, 0, 1, 3'd0, 3'd0, "stall_s2");
    drive(0, 1, 5'd3, 1, 5'd0, 0, 5'd0, 0, 0, 0, 1, 3'd0, 3'd0, "stall_s3_wb");
    drive(0, 1, 5'd3, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0, 3'd0, 3'd0, "stall_released");
    idle("cnt_is_3");
    wr_ins(5'd0, 0, "wr_x0");
    drive(0, 1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0, 0, 3'd0, 3'd0, "x0_no_hit");
    wr_ins(5'd9, 0, "addi_x9");
    idle("gap");
    drive(0, 1, 5'd0, 0, 5'd9, 1, 5'd0, 0, 0, 0, 1, 3'd0, 3'd0, "rs2_stall_s2");
    drive(0, 1, 5'd0, 0, 5'd9, 1, 5'd0, 0, 0, 0, 1, 3'd0, 3'd0, "rs2_stall_s3");
    drive(0, 1, 5'd0, 0, 5'd9, 1, 5'd0, 0, 0, 0, 0, 3'd0, 3'd0, "rs2_released");
    idle("sat_hold");
    wr_ins(5'd4, 0, "addi_x4");
    drive(0, 1, 5'd4, 1, 5'd0, 0, 5'd6, 1, 0, 1, 0, 3'd0, 3'd0, "flush_beats_stall");
    drive(0, 1, 5'd6, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0, 3'd0, 3'd0, "flushed_bubble");
    wr_ins(5'd5, 0, "addi_x5");
    drive(0, 1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0, 1, 3'd0, 3'd0, "pre_reset_stall");
    drive(1, 1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0, 3'd0, 3'd0, "reset_mid_stall");
`endif
    idle("after_reset");
    idle("final_idle");
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending records, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/otter_hazard_unit.md
OTTER_HAZARD_UNIT -- requirements
Module: otter_hazard_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 3, meaning the number of tracked in-flight stages after decode (stage 1 = execute ... stage DEPTH = writeback); legal range 2..6.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the stall counter.
REQ-003 SHALL have one clock; reset is asynchronous and active-high: CLK  in  1  rising-edge clock.
REQ-004 RST  in  1  asynchronous active-high reset.
REQ-005 DEC_VALID  in  1  decode register holds a real instruction.
REQ-006 DEC_RS1, DEC_RS2  in  5 each  decode source register addresses.
REQ-007 DEC_USE1, DEC_USE2  in  1 each  the decode instruction reads RS1 / RS2.
REQ-008 DEC_RD  in  5  decode destination address.
REQ-009 DEC_WR  in  1  the decode instruction writes RD.
REQ-010 DEC_LOAD  in  1  the decode instruction is a load.
REQ-011 BR_TAKEN  in  1  the execute stage redirects the PC this cycle.
REQ-012 STALL  out  1  hold PC and decode register; the PC_WRITE equivalent is !STALL.
REQ-013 FLUSH  out  1  clear the decode register at the next edge.
REQ-014 FWD_A, FWD_B  out  3 each  operand source: 0 = register file, k = stage k result.
REQ-015 STALL_CNT  out  CNT_W  saturating count of stall cycles.

Function
REQ-016 SHALL keep a shift chain of DEPTH entries {valid, rd, load}; entry k describes the instruction in stage k.
REQ-017 On each edge, entry k+1 SHALL take entry k and entry DEPTH SHALL be discarded.
REQ-018 Entry 1 SHALL take {DEC_VALID & DEC_WR & rd!=0, DEC_RD, DEC_LOAD} when STALL=0 and FLUSH=0, and otherwise SHALL take a bubble (valid=0).
REQ-019 A hit on stage k for operand n SHALL mean: entry k valid, entry k rd==DEC_RSn, DEC_USEn=1 and DEC_VALID=1; register x0 SHALL never hit.
REQ-020 STALL, FLUSH, FWD_A and FWD_B SHALL be combinational from the current entries and the decode inputs, with zero latency.
REQ-021 FLUSH SHALL equal BR_TAKEN.
REQ-022 FLUSH SHALL force STALL=0 in the same cycle, so flush wins over stall.
REQ-023 When operands hit in several stages, the lowest k (youngest) SHALL be selected.
REQ-024 STALL_CNT SHALL increment on every edge where STALL=1 and SHALL hold at all-ones.
REQ-025 A stall SHALL persist exactly until the blocking entry leaves the hit condition; no extra cycles SHALL be inserted.

Reset
REQ-026 While RST=1, all entries SHALL be invalid and STALL_CNT SHALL be 0, which gives STALL=0, FLUSH=BR_TAKEN and FWD_A=FWD_B=0.
REQ-027 Reset asserted mid-stall SHALL release the stall immediately, asynchronously.

Configuration
REQ-028 With the macro OTTER_HAZ_FWD_EN defined:
- STALL=1 only on a hit at stage 1 whose entry has load=1 (load-use).
- Otherwise FWD_A/FWD_B SHALL report the youngest hit stage.
- A load at stage 2..DEPTH SHALL be forwarded.
REQ-029 Without OTTER_HAZ_FWD_EN:
- FWD_A and FWD_B SHALL be constant 0.
- STALL=1 on any hit in stages 1..DEPTH, including writeback, because the register file writes at the end of the cycle.

Verification
REQ-030 Reset then idle -> STALL=0, FWD=0, STALL_CNT=0; assert RST during a stall -> STALL drops the same cycle.
REQ-031 DEPTH=3, forwarding on: `add x5` followed by `sub` using rs1=x5 -> no stall, FWD_A=1 for one cycle; with one instruction between them -> FWD_A=2.
REQ-032 DEPTH=3, forwarding on: `lw x7` followed by a use of x7 -> STALL=1 for exactly 1 cycle, then FWD=2, and STALL_CNT=1.
REQ-033 DEPTH=3, forwarding off: `addi x3` followed by a use of x3 -> STALL=1 for exactly 3 cycles, STALL_CNT=3, FWD stays 0; a write to x0 followed by a use of x0 -> no stall.
REQ-034 BR_TAKEN=1 while decode is stalled on a hit -> FLUSH=1, STALL=0, and entry 1 becomes a bubble on the next edge.
REQ-035 CNT_W=2: hold STALL high for 5 cycles -> STALL_CNT reaches 3 and stays at 3.
